uart_tx_cfg: RTL and testbench
==============================

UART_TX_CFG -- requirements
Module: uart_tx_cfg

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning data bits per frame; legal range 5..9.
REQ-002 The block SHALL have parameter PARITY, default 0, meaning parity mode: 0 none, 1 odd, 2 even.
REQ-003 The block SHALL have parameter STOP_BITS, default 1, meaning stop bits per frame; legal values 1 or 2.
REQ-004 The block SHALL have parameter CLKS_PER_BIT, default 16, meaning clock cycles per serial bit; legal minimum 2.
REQ-005 The block SHALL have parameter FIFO_DEPTH, default 4, meaning transmit buffer entries; power of two, minimum 2.
REQ-006 The block SHALL have port tx_sclk_i, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-007 The block SHALL have port tx_srst_i, input, 1 bit, the reset; it is synchronous and active-high.
REQ-008 The block SHALL have port tx_pdata_i, input, DATA_W bits, the parallel word to send.
REQ-009 The block SHALL have port tx_pdata_valid_i, input, 1 bit, which marks tx_pdata_i as valid.
REQ-010 The block SHALL have port tx_pready_o, output, 1 bit, which is high when the FIFO can accept a word.
REQ-011 The block SHALL have port tx_sdata_o, output, 1 bit, the serial line; it idles high.
REQ-012 The block SHALL have port tx_busy_o, output, 1 bit, which is high whenever the FSM is not in IDLE.
REQ-013 The block SHALL have port tx_done_o, output, 1 bit, a one-cycle pulse at end of frame.
REQ-014 The block SHALL have port tx_fifo_cnt_o, output, $clog2(FIFO_DEPTH)+1 bits, the current FIFO occupancy.

Function
REQ-015 The block SHALL accept a word only on a rising edge where tx_pdata_valid_i=1 and tx_pready_o=1; all other valid cycles are ignored with no side effect.
REQ-016 tx_pready_o SHALL be registered and SHALL equal (count<FIFO_DEPTH) after each edge; there is no same-cycle bypass when full, even if a pop occurs in that cycle.
REQ-017 The FIFO SHALL be first-in first-out with wrap-around pointers; a simultaneous push and pop SHALL leave the count unchanged.
REQ-018 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP, each held for exactly CLKS_PER_BIT cycles per bit, counted by a baud counter that resets on every bit boundary.
REQ-019 In IDLE with count>0, the FSM SHALL pop the head word into a shift register on the next edge and enter START.
REQ-020 From acceptance into an empty FIFO with the FSM in IDLE at edge E, tx_sdata_o SHALL go low after edge E+2.
REQ-021 The frame SHALL be start bit 0, then DATA_W bits LSB first, then a parity bit if PARITY!=0, then STOP_BITS bits of 1.
REQ-022 The parity bit SHALL be the XOR of the data bits for even mode, and the inverted XOR of the data bits for odd mode.
REQ-023 DATA SHALL be followed by PARITY when PARITY!=0, and otherwise by STOP; the bit index SHALL run 0..DATA_W-1 and then return to 0.
REQ-024 On the last cycle of the last stop bit, tx_done_o SHALL be 1 for one cycle; the FSM SHALL then pop and enter START if count>0 (no idle gap), and otherwise enter IDLE.
REQ-025 Frame length SHALL be (1+DATA_W+(PARITY!=0)+STOP_BITS)*CLKS_PER_BIT cycles exactly.
REQ-026 tx_sdata_o SHALL be driven from a register, with no combinational path from any input.
REQ-027 Pushes during a frame SHALL NOT disturb the frame in flight.

Reset
REQ-028 While tx_srst_i=1 at an edge, the block SHALL set tx_sdata_o=1, tx_pready_o=1, tx_busy_o=0, tx_done_o=0, tx_fifo_cnt_o=0, FSM=IDLE, and pointers and counters to 0.
REQ-029 Reset asserted mid-frame SHALL abort the frame; the line SHALL be high after that edge and all FIFO contents SHALL be discarded.
REQ-030 A push presented in the same cycle as reset SHALL be dropped.

Verification
REQ-031 With DATA_W=8, PARITY=0, STOP_BITS=1, CLKS_PER_BIT=4, pushing 0xA5 SHALL produce line bits 0,1,0,1,0,0,1,0,1,1 at 4 cycles each (40 cycles), with tx_done_o pulsed once.
REQ-032 With PARITY=2, pushing 0xA5 SHALL give parity bit 0; with PARITY=1, pushing 0xA5 SHALL give parity bit 1; frame length SHALL be 44 cycles.
REQ-033 With FIFO_DEPTH=4, five back-to-back pushes (0x01..0x05) while idle SHALL be handled as follows: 0x05 is rejected if the FIFO is full at that edge, and the accepted words are sent in order with no high gap between the stop bit and the next start bit.
REQ-034 With STOP_BITS=2 and CLKS_PER_BIT=4, pushing 0x00 SHALL produce a line low for 36 cycles and then high for 8 cycles, with tx_done_o on cycle 44.
REQ-035 Asserting reset on cycle 10 of a frame with 2 words queued SHALL give tx_sdata_o=1, tx_fifo_cnt_o=0, tx_pready_o=1 and tx_busy_o=0 after that edge, and no further frames.
REQ-036 Holding tx_pdata_valid_i=1 while tx_pready_o=0 for 20 cycles SHALL leave the FIFO contents and tx_fifo_cnt_o unchanged.

Source files
------------

// File: rtl/uart_tx_cfg.sv
// Buffered UART transmitter: small FIFO feeding a start/data/parity/stop serializer.
// The serial line and end-of-frame pulse are retimed one cycle behind the FSM state.
module uart_tx_cfg #(
  parameter int DATA_W       = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          tx_sclk_i,
  input  logic                          tx_srst_i,
  input  logic [DATA_W-1:0]             tx_pdata_i,
  input  logic                          tx_pdata_valid_i,
  output logic                          tx_pready_o,
  output logic                          tx_sdata_o,
  output logic                          tx_busy_o,
  output logic                          tx_done_o,
  output logic [$clog2(FIFO_DEPTH):0]   tx_fifo_cnt_o
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = $clog2(DATA_W);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count, count_n;
  logic              pready;
  state_t            state, state_n;
  logic [BW-1:0]     baud, baud_n;
  logic [IW-1:0]     bit_idx, bit_n;
  logic [DATA_W-1:0] shreg;
  logic              push, pop, baud_last, frame_end, line_bit;
  logic              sdata_p1, done_p1;

  function automatic logic parity_bit(input logic [DATA_W-1:0] d);
    return (PARITY == 1) ? ~(^d) : (^d);
  endfunction

  assign push      = tx_pdata_valid_i & pready & ~tx_srst_i;
  assign count_n   = count + CW'(push) - CW'(pop);
  assign baud_last = (baud == BW'(CLKS_PER_BIT - 1));

  always_comb begin
    state_n   = state;
    baud_n    = baud_last ? '0 : baud + 1'b1;
    bit_n     = bit_idx;
    pop       = 1'b0;
    frame_end = 1'b0;
    line_bit  = 1'b1;
    case (state)
      S_IDLE: begin
        baud_n = '0;
        bit_n  = '0;
        if (count != '0) begin
          pop     = 1'b1;
          state_n = S_START;
        end
      end
      S_START: begin
        line_bit = 1'b0;
        if (baud_last) state_n = S_DATA;
      end
      S_DATA: begin
        line_bit = shreg[bit_idx];
        if (baud_last) begin
          if (bit_idx == IW'(DATA_W - 1)) begin
            bit_n   = '0;
            state_n = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_n = bit_idx + 1'b1;
          end
        end
      end
      S_PARITY: begin
        line_bit = parity_bit(shreg);
        if (baud_last) state_n = S_STOP;
      end
      S_STOP: begin
        if (baud_last) begin
          if (bit_idx == IW'(STOP_BITS - 1)) begin
            frame_end = 1'b1;
            bit_n     = '0;
            // Chain straight into the next start bit when more words wait.
            if (count != '0) begin
              pop     = 1'b1;
              state_n = S_START;
            end else begin
              state_n = S_IDLE;
            end
          end else begin
            bit_n = bit_idx + 1'b1;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // p0: FIFO pointers, occupancy and FSM state
  always_ff @(posedge tx_sclk_i) begin
    if (tx_srst_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      pready   <= 1'b1;
      state    <= S_IDLE;
      baud     <= '0;
      bit_idx  <= '0;
      sdata_p1 <= 1'b1;
      done_p1  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count    <= count_n;
      pready   <= (count_n < CW'(FIFO_DEPTH));
      state    <= state_n;
      baud     <= baud_n;
      bit_idx  <= bit_n;
      // p1: retimed line level and end-of-frame strobe
      sdata_p1 <= line_bit;
      done_p1  <= frame_end;
    end
  end

  always_ff @(posedge tx_sclk_i) begin
    if (push) mem[wr_ptr] <= tx_pdata_i;
    if (pop)  shreg       <= mem[rd_ptr];
  end

  assign tx_pready_o   = pready;
  assign tx_sdata_o    = sdata_p1;
  assign tx_done_o     = done_p1;
  assign tx_busy_o     = (state != S_IDLE);
  assign tx_fifo_cnt_o = count;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg: four parity/stop variants share one stimulus stream,
// line and done are recorded per cycle and compared against hand-built frames.
module tb_uart_tx_cfg;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] pdata;
  logic       pvalid;

  logic       rdy_a, sd_a, busy_a, done_a;
  logic       rdy_b, sd_b, busy_b, done_b;
  logic       rdy_c, sd_c, busy_c, done_c;
  logic       rdy_d, sd_d, busy_d, done_d;
  logic [2:0] cnt_a, cnt_b, cnt_c, cnt_d;

  int n_checks = 0;
  int n_fail   = 0;

  logic [255:0] cap_a, cap_b, cap_c, cap_d;
  logic [255:0] dn_a, dn_b, dn_c, dn_d;
  int           cap_n;
  bit           cap_en;

  logic [63:0]  fb5;

  always #5 clk = ~clk;

  uart_tx_cfg #(.DATA_W(8), .PARITY(0), .STOP_BITS(1), .CLKS_PER_BIT(4), .FIFO_DEPTH(4)) u_a (
    .tx_sclk_i(clk), .tx_srst_i(rst), .tx_pdata_i(pdata), .tx_pdata_valid_i(pvalid),
    .tx_pready_o(rdy_a), .tx_sdata_o(sd_a), .tx_busy_o(busy_a), .tx_done_o(done_a),
    .tx_fifo_cnt_o(cnt_a));

  uart_tx_cfg #(.DATA_W(8), .PARITY(2), .STOP_BITS(1), .CLKS_PER_BIT(4), .FIFO_DEPTH(4)) u_b (
    .tx_sclk_i(clk), .tx_srst_i(rst), .tx_pdata_i(pdata), .tx_pdata_valid_i(pvalid),
    .tx_pready_o(rdy_b), .tx_sdata_o(sd_b), .tx_busy_o(busy_b), .tx_done_o(done_b),
    .tx_fifo_cnt_o(cnt_b));

  uart_tx_cfg #(.DATA_W(8), .PARITY(1), .STOP_BITS(1), .CLKS_PER_BIT(4), .FIFO_DEPTH(4)) u_c (
    .tx_sclk_i(clk), .tx_srst_i(rst), .tx_pdata_i(pdata), .tx_pdata_valid_i(pvalid),
    .tx_pready_o(rdy_c), .tx_sdata_o(sd_c), .tx_busy_o(busy_c), .tx_done_o(done_c),
    .tx_fifo_cnt_o(cnt_c));

  uart_tx_cfg #(.DATA_W(8), .PARITY(0), .STOP_BITS(2), .CLKS_PER_BIT(4), .FIFO_DEPTH(4)) u_d (
    .tx_sclk_i(clk), .tx_srst_i(rst), .tx_pdata_i(pdata), .tx_pdata_valid_i(pvalid),
    .tx_pready_o(rdy_d), .tx_sdata_o(sd_d), .tx_busy_o(busy_d), .tx_done_o(done_d),
    .tx_fifo_cnt_o(cnt_d));

  task automatic tick;
    @(posedge clk);
    #1;
    if (cap_en && cap_n < 256) begin
      cap_a[cap_n] = sd_a;  dn_a[cap_n] = done_a;
      cap_b[cap_n] = sd_b;  dn_b[cap_n] = done_b;
      cap_c[cap_n] = sd_c;  dn_c[cap_n] = done_c;
      cap_d[cap_n] = sd_d;  dn_d[cap_n] = done_d;
      cap_n++;
    end
  endtask

  task automatic cap_start;
    cap_n  = 0;
    cap_a  = '0; cap_b = '0; cap_c = '0; cap_d = '0;
    dn_a   = '0; dn_b  = '0; dn_c  = '0; dn_d  = '0;
    cap_en = 1'b1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Line level per sample: frame bit k/4 (4 clocks per bit), idle high after the frame.
  function automatic logic [255:0] exp_wave(input logic [63:0] fb, input int nbits, input int nsamp);
    logic [255:0] w;
    w = '0;
    for (int k = 0; k < nsamp; k++) w[k] = (k / 4 < nbits) ? fb[k / 4] : 1'b1;
    return w;
  endfunction

  function automatic logic [255:0] exp_done(input int flen, input int nfr, input int nsamp);
    logic [255:0] w;
    w = '0;
    for (int m = 0; m < nfr; m++)
      if (m * flen + flen - 1 < nsamp) w[m * flen + flen - 1] = 1'b1;
    return w;
  endfunction

  initial begin
    cap_en = 1'b0;
    cap_n  = 0;
    rst    = 1'b1;
    pvalid = 1'b1;
    pdata  = 8'h5A;
    tick;
    tick;
    chk("rst_sdata", sd_a, 1);
    chk("rst_pready", rdy_a, 1);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_cnt", cnt_a, 0);
    rst    = 1'b0;
    pvalid = 1'b0;
    tick;
    chk("post_rst_cnt", cnt_a, 0);

    // single frame 0xA5 on all four variants
    pdata  = 8'hA5;
    pvalid = 1'b1;
    tick;
    pvalid = 1'b0;
    chk("acc_cnt", cnt_a, 1);
    chk("acc_line_idle", sd_a, 1);
    tick;
    chk("start_busy", busy_a, 1);
    chk("start_cnt", cnt_a, 0);
    chk("start_line_still_high", sd_a, 1);
    cap_start;
    repeat (48) tick;
    cap_en = 1'b0;
    chk("a5_none_wave", cap_a, exp_wave(64'b1101001010, 10, 48));
    chk("a5_none_done", dn_a, exp_done(40, 1, 48));
    chk("a5_even_wave", cap_b, exp_wave(64'b10101001010, 11, 48));
    chk("a5_even_done", dn_b, exp_done(44, 1, 48));
    chk("a5_odd_wave", cap_c, exp_wave(64'b11101001010, 11, 48));
    chk("a5_odd_done", dn_c, exp_done(44, 1, 48));
    chk("a5_stop2_wave", cap_d, exp_wave(64'b11101001010, 11, 48));
    chk("a5_stop2_done", dn_d, exp_done(44, 1, 48));
    chk("a5_all_idle", {busy_a, busy_b, busy_c, busy_d}, 4'b0000);

    // single frame 0x00
    pdata  = 8'h00;
    pvalid = 1'b1;
    tick;
    pvalid = 1'b0;
    tick;
    cap_start;
    repeat (48) tick;
    cap_en = 1'b0;
    chk("z_none_wave", cap_a, exp_wave(64'b1000000000, 10, 48));
    chk("z_none_done", dn_a, exp_done(40, 1, 48));
    chk("z_even_wave", cap_b, exp_wave(64'b10000000000, 11, 48));
    chk("z_odd_wave", cap_c, exp_wave(64'b11000000000, 11, 48));
    chk("z_stop2_wave", cap_d, exp_wave(64'b11000000000, 11, 48));
    chk("z_stop2_done", dn_d, exp_done(44, 1, 48));

    // five back-to-back pushes, then hold valid against a full FIFO
    pdata  = 8'h01;
    pvalid = 1'b1;
    tick;
    pdata  = 8'h02;
    tick;
    cap_start;
    pdata  = 8'h03;
    tick;
    pdata  = 8'h04;
    tick;
    chk("fifo_rdy_before_5th", rdy_a, 1);
    pdata  = 8'h05;
    tick;
    chk("fifo_full_cnt", cnt_a, 4);
    chk("fifo_full_rdy", rdy_a, 0);
    pdata  = 8'h06;
    repeat (20) tick;
    chk("hold_cnt", cnt_a, 4);
    chk("hold_rdy", rdy_a, 0);
    pvalid = 1'b0;
    while (cap_n < 204) tick;
    cap_en = 1'b0;
    fb5 = {1'b1, 8'h05, 1'b0, 1'b1, 8'h04, 1'b0, 1'b1, 8'h03, 1'b0,
           1'b1, 8'h02, 1'b0, 1'b1, 8'h01, 1'b0};
    chk("b2b_wave", cap_a, exp_wave(fb5, 50, 204));
    chk("b2b_done", dn_a, exp_done(40, 5, 204));
    chk("b2b_idle", {busy_a, cnt_a}, 4'b0000);

    // reset on cycle 10 of a frame with two words queued
    pdata  = 8'h00;
    pvalid = 1'b1;
    tick;
    pdata  = 8'h11;
    tick;
    pdata  = 8'h22;
    tick;
    pvalid = 1'b0;
    repeat (9) tick;
    chk("mid_line_low", sd_a, 0);
    chk("mid_cnt", cnt_a, 2);
    chk("mid_busy", busy_a, 1);
    rst = 1'b1;
    tick;
    chk("abort_sdata", sd_a, 1);
    chk("abort_cnt", cnt_a, 0);
    chk("abort_rdy", rdy_a, 1);
    chk("abort_busy", busy_a, 0);
    chk("abort_done", done_a, 0);
    chk("abort_others", {rdy_b, rdy_c, rdy_d, busy_b, busy_c, busy_d, sd_b, sd_c, sd_d,
                         done_b, done_c, done_d, cnt_b, cnt_c, cnt_d},
        {3'b111, 3'b000, 3'b111, 3'b000, 9'd0});
    rst = 1'b0;
    cap_start;
    repeat (60) tick;
    cap_en = 1'b0;
    chk("after_abort_line", cap_a, exp_wave(64'h0, 0, 60));
    chk("after_abort_done", dn_a, 256'h0);
    chk("after_abort_state", {busy_a, cnt_a}, 4'b0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
